// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer pair.
// Optional macro SERIALIZER_PARITY_EN adds the PARITY state to the enum.
package serial_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE   = 2'd2
`ifdef SERIALIZER_PARITY_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/serializer.sv
// Byte-to-bit serializer, MSB first, with a per-bit ready handshake.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit after bit 7.
module serializer
  import serial_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ack,
  output logic              serial_out,
  output logic              serial_valid,
  input  logic              serial_ready,
  output logic              busy_out,
  output logic              frame_done
);

  state_t            state;
  state_t            state_nxt;
  logic [BYTE_W-1:0] shift_reg;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              last_bit;

  assign accept   = (state == IDLE) && data_valid;
  assign last_bit = (count == CNT_W'(BYTE_W - 1));

`ifdef SERIALIZER_PARITY_EN
  logic parity_bit;

  // Capture even parity of the byte at accept time; the shift register is
  // empty by the time the parity bit is presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^data_in;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register, bit counter and the registered accept pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      count     <= '0;
      data_ack  <= 1'b0;
    end else begin
      data_ack <= accept;
      if (accept) begin
        shift_reg <= data_in;
        count     <= '0;
      end else if ((state == SEND) && serial_ready) begin
        shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
        count     <= count + CNT_W'(1);
      end
    end
  end

  // Next-state logic and state-decoded outputs; serial_out stays 0 when not valid.
  always_comb begin
    state_nxt    = state;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    busy_out     = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_valid) state_nxt = SEND;
      end
      SEND: begin
        serial_valid = 1'b1;
        busy_out     = 1'b1;
        serial_out   = shift_reg[BYTE_W-1];
        if (serial_ready && last_bit) begin
`ifdef SERIALIZER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        serial_valid = 1'b1;
        busy_out     = 1'b1;
        serial_out   = parity_bit;
        if (serial_ready) state_nxt = DONE;
      end
`endif
      DONE: begin
        busy_out   = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: frame-position model checked every
// cycle plus directed scenarios with literal expectations.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB        = 9;
  localparam int FRAME_LEN = 11;
  localparam int ACK_GAP   = 11;
`else
  localparam int NB        = 8;
  localparam int FRAME_LEN = 10;
  localparam int ACK_GAP   = 10;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ack;
  logic       serial_out;
  logic       serial_valid;
  logic       serial_ready;
  logic       busy_out;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: pos = -1 idle, 0..7 data bit index, 8 parity, NB = done.
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic       m_ack = 1'b0;

  logic acc_bits[$];
  logic pres_bits[$];
  int   valid_cyc[$];
  int   ack_cyc[$];
  int   done_cyc[$];

  serializer dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .serial_ready(serial_ready),
    .busy_out    (busy_out),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model update and cycle count on the active edge.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      m_pos = -1;
      m_ack = 1'b0;
      m_byte = 8'h00;
    end else begin
      m_ack = 1'b0;
      if (m_pos == -1) begin
        if (data_valid) begin
          m_byte = data_in;
          m_pos  = 0;
          m_ack  = 1'b1;
        end
      end else if (m_pos < NB) begin
        if (serial_ready) m_pos = m_pos + 1;
      end else begin
        m_pos = -1;
      end
    end
  end

  function automatic logic [4:0] model_out();
    logic v, o, b, d;
    v = (m_pos >= 0) && (m_pos < NB);
    b = (m_pos >= 0);
    d = (m_pos == NB);
    o = 1'b0;
    if (v) o = (m_pos < 8) ? m_byte[7 - m_pos] : ^m_byte;
    return {m_ack, o, v, b, d};
  endfunction

  // Per-cycle compare against the model, plus event logging.
  always @(negedge clock) begin
    logic [4:0] act, exp;
    act = {data_ack, serial_out, serial_valid, busy_out, frame_done};
    exp = reset ? 5'b0 : model_out();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_compare cyc=%0d {ack,out,vld,busy,done} got %b expected %b", cyc, act, exp);
    end
    if (serial_valid) begin
      pres_bits.push_back(serial_out);
      valid_cyc.push_back(cyc);
      if (serial_ready) acc_bits.push_back(serial_out);
    end
    if (data_ack) ack_cyc.push_back(cyc);
    if (frame_done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    acc_bits.delete();
    pres_bits.delete();
    valid_cyc.delete();
    ack_cyc.delete();
    done_cyc.delete();
  endtask

  function automatic int pack_acc(input int start);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], acc_bits[start + i]};
    return int'(v);
  endfunction

  initial begin
    reset = 1'b1;
    data_in = 8'h00;
    data_valid = 1'b0;
    serial_ready = 1'b1;
    step(2);
    chk("reset_outputs", int'({data_ack, serial_out, serial_valid, busy_out, frame_done}), 0);
    reset = 1'b0;
    step(2);

    // 0xA5, no stalls.
    clear_logs();
    data_in = 8'hA5; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(14);
    chk("a5_bit_count", acc_bits.size(), NB);
    if (acc_bits.size() >= 8) chk("a5_bits", pack_acc(0), 8'hA5);
    chk("a5_ack_pulses", ack_cyc.size(), 1);
    chk("a5_done_pulses", done_cyc.size(), 1);
    if (ack_cyc.size() == 1 && valid_cyc.size() == NB && done_cyc.size() == 1) begin
      chk("a5_first_bit_cycle", valid_cyc[0], ack_cyc[0]);
      chk("a5_bits_consecutive", valid_cyc[7] - valid_cyc[0], 7);
      chk("a5_done_after_last", done_cyc[0] - valid_cyc[NB-1], 1);
    end

    // 0x3C with a 3-cycle stall while bit 2 is presented.
    clear_logs();
    data_in = 8'h3C; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(2);
    serial_ready = 1'b0;
    step(3);
    serial_ready = 1'b1;
    step(14);
    if (acc_bits.size() >= 8) chk("3c_bits", pack_acc(0), 8'h3C);
    chk("3c_valid_cycles", valid_cyc.size(), 11 + (NB - 8));
    if (pres_bits.size() >= 11) begin
      logic [10:0] seq;
      seq = '0;
      for (int i = 0; i < 11; i++) seq = {seq[9:0], pres_bits[i]};
      chk("3c_presented_seq", int'(seq), int'(11'b00111111100));
    end

    // 0xFF then 0x00 back to back with data_valid held.
    clear_logs();
    data_in = 8'hFF; data_valid = 1'b1;
    step(1);
    data_in = 8'h00;
    step(NB + 2);
    data_valid = 1'b0;
    step(14);
    chk("b2b_ack_pulses", ack_cyc.size(), 2);
    chk("b2b_bit_count", acc_bits.size(), 2 * NB);
    if (ack_cyc.size() == 2) chk("b2b_ack_gap", ack_cyc[1] - ack_cyc[0], ACK_GAP);
    if (acc_bits.size() == 2 * NB) begin
      chk("b2b_byte0", pack_acc(0), 8'hFF);
      chk("b2b_byte1", pack_acc(NB), 8'h00);
    end
    if (valid_cyc.size() == 2 * NB) chk("b2b_frame_gap", valid_cyc[NB] - valid_cyc[NB-1], 3);

    // data_in/data_valid change mid-frame must not matter.
    clear_logs();
    data_in = 8'h81; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(2);
    data_in = 8'h7E; data_valid = 1'b1;
    step(4);
    data_valid = 1'b0; data_in = 8'h00;
    step(14);
    chk("midframe_ack_pulses", ack_cyc.size(), 1);
    if (acc_bits.size() >= 8) chk("midframe_bits", pack_acc(0), 8'h81);

    // 0x07: parity bit (when enabled) and frame length.
    clear_logs();
    data_in = 8'h07; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(14);
    chk("p07_bit_count", acc_bits.size(), NB);
    if (acc_bits.size() >= 8) chk("p07_bits", pack_acc(0), 8'h07);
`ifdef SERIALIZER_PARITY_EN
    if (acc_bits.size() == 9) chk("p07_parity_bit", int'(acc_bits[8]), 1);
`endif
    if (ack_cyc.size() == 1 && done_cyc.size() == 1)
      chk("p07_frame_len", done_cyc[0] - ack_cyc[0] + 2, FRAME_LEN);

    // Reset after 3 accepted bits.
    data_in = 8'hC3; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(3);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", int'({data_ack, serial_out, serial_valid, busy_out, frame_done}), 0);
    clear_logs();
    step(1);
    reset = 1'b0;
    step(4);
    chk("midreset_idle_busy", int'(busy_out), 0);
    chk("midreset_no_resume", valid_cyc.size(), 0);
    chk("midreset_no_ack", ack_cyc.size(), 0);

    // First accept after reset.
    clear_logs();
    data_in = 8'h5A; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(14);
    if (acc_bits.size() >= 8) chk("post_reset_bits", pack_acc(0), 8'h5A);
    chk("post_reset_ack", ack_cyc.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
